// File: rtl/segmentos_mux.sv
// segmentos_mux: time-multiplexed multi-digit 7-segment display driver.
//
// A binary value is loaded, converted to BCD (sequential double-dabble, one bit per cycle)
// or taken as hex nibbles, and committed to a digit register. A free-running scan counter
// then walks the digits onto a shared active-low segment bus with active-low anodes.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   in_data   binary value to display
//   in_valid  load request, accepted only while idle
//   in_hex    1 = hex mode, 0 = decimal mode (sampled with in_valid)
//   blank_lz  1 = blank leading zero digits (live)
//   busy      conversion in progress, loads dropped
//   seg       segments {g,f,e,d,c,b,a}, active-low, registered
//   an        digit enables, active-low one-hot, registered
module segmentos_mux #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DATA_W   = 14,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_hex,
  input  logic              blank_lz,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  // Number of decimal digits needed to hold 2^w - 1.
  function automatic int unsigned dec_digits(input int unsigned w);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

  localparam int unsigned BcdNeed   = dec_digits(DATA_W);
  // BCD register is at least DIGITS wide so the display slice always exists.
  localparam int unsigned BcdDigits = (BcdNeed > DIGITS) ? BcdNeed : DIGITS;
  localparam int unsigned BcdW      = 4 * BcdDigits;
  localparam int unsigned DispW     = 4 * DIGITS;
  localparam int unsigned HexW      = (DATA_W > DispW) ? DATA_W : DispW;
  localparam int unsigned CntW      = $clog2(SCAN_DIV);
  localparam int unsigned IdxW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BitW      = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              hex_q, hex_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [BitW-1:0]   bitcnt_q, bitcnt_d;
  logic [DispW-1:0]  digits_q, digits_d;
  logic              ovf_q, ovf_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic [BcdW-1:0]        bcd_adj;
  logic [BcdW+DATA_W-1:0] shift_vec;
  logic [HexW-1:0]        hex_ext;
  logic [DispW-1:0]       upper;
  logic [6:0]             seg_sel;

  // Double-dabble step: add 3 to every nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < int'(BcdDigits); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
    shift_vec = {bcd_adj, data_q} << 1;
    hex_ext   = HexW'(data_q);
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    hex_d    = hex_q;
    bcd_d    = bcd_q;
    bitcnt_d = bitcnt_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d   = in_data;
          hex_d    = in_hex;
          bcd_d    = '0;
          bitcnt_d = '0;
          state_d  = in_hex ? StDone : StShift;
        end
      end
      StShift: begin
        {bcd_d, data_d} = shift_vec;
        bitcnt_d        = bitcnt_q + BitW'(1);
        if (bitcnt_q == BitW'(DATA_W - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (hex_q) begin
          digits_d = hex_ext[DispW-1:0];
          ovf_d    = |(hex_ext >> DispW);
        end else begin
          digits_d = bcd_q[DispW-1:0];
          ovf_d    = |(bcd_q >> DispW);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Digits at and above the scanned one; all zero means this digit is a leading zero.
  always_comb begin
    upper = digits_q >> {idx_q, 2'b00};
    if (ovf_q) begin
      seg_sel = 7'h3F;
    end else if (blank_lz && (idx_q != '0) && (upper == '0)) begin
      seg_sel = 7'h7F;
    end else begin
      seg_sel = glyph(upper[3:0]);
    end
  end

  // Slot update shows the current index, then advances it, so the first wrap shows digit 0.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    seg_d = seg_q;
    an_d  = an_q;
    if (cnt_q == CntW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = seg_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      data_q   <= '0;
      hex_q    <= 1'b0;
      bcd_q    <= '0;
      bitcnt_q <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_q    <= 7'h7F;
      an_q     <= '1;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      hex_q    <= hex_d;
      bcd_q    <= bcd_d;
      bitcnt_q <= bitcnt_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: doc/segmentos_mux.md
Name: segmentos_mux

Overview:
Multi-digit, time-multiplexed 7-segment display driver. It accepts a binary value, converts it to decimal (sequential double-dabble) or hex digits, and stores the result in a digit register. It then scans the digits onto one shared active-low segment bus with active-low anode enables. It sits between user/UART datapath logic and the board's multi-digit display.

Parameters:
DIGITS, 4, number of display digits (1..8).
DATA_W, 14, width of input binary value (1..27).
SCAN_DIV, 50000, clk cycles per digit slot (>=2).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
in_data  input  DATA_W  binary value to display.
in_valid  input  1  load request; sampled each cycle.
in_hex  input  1  sampled with in_valid: 1 = hex mode, 0 = decimal mode.
blank_lz  input  1  live input: 1 = blank leading zero digits.
busy  output  1  conversion in progress; loads are ignored while high.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
an  output  DIGITS  digit enables, active-low one-hot, registered.

Behaviour:
- Reset (rst_n=0 at a clk edge): busy=0, seg=7'h7F, an=all 1s, scan counter=0, scan index=0, digit register=all zero, overflow flag=0, FSM=IDLE. Reset mid-conversion aborts it; the pending value is discarded.
- Accept: in_valid=1 and busy=0 at edge k. in_data and in_hex are latched. in_valid while busy=1 is dropped with no queueing.
- FSM states and transitions:
  - IDLE -> SHIFT (decimal) or IDLE -> DONE (hex).
  - SHIFT runs DATA_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift left one bit.
  - DONE lasts 1 cycle, then returns to IDLE.
  - The internal BCD register holds enough digits for 2^DATA_W-1.
- Latency and busy:
  - Decimal: busy=1 for cycles k+1..k+DATA_W+1; new digits visible in the digit register from k+DATA_W+2.
  - Hex: busy=1 for cycle k+1; new digits visible from k+2.
- Digit register commit happens in DONE only. The old value is displayed until then.
- Overflow:
  - Decimal: set if any BCD digit at position >= DIGITS is non-zero.
  - Hex: set if in_data bits at position >= 4*DIGITS are non-zero.
  - When overflow is set, all digits show dash 7'h3F, regardless of blank_lz.
- Digit encoding (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18.
  - A=08, b=03, C=46, d=21, E=06, F=0E.
  - A blanked digit shows 7'h7F.
- Blanking: with blank_lz=1, every digit above the most significant non-zero digit shows 7'h7F. Digit 0 is never blanked, so value 0 shows "0".
- Scan:
  - The counter counts 0..SCAN_DIV-1 and wraps.
  - On each wrap, the scan index advances (DIGITS-1 wraps to 0). In the same edge, an gets a 0 at bit[index] and seg gets the encoding for that digit.
  - First wrap after reset selects index 0, so an[0]=0 at cycle SCAN_DIV after reset.
  - Scanning is unaffected by loads. A commit landing mid-slot appears at the next slot update.
- Digit 0 is the least significant digit and is driven on an[0].

Test Plan:
- DIGITS=4, DATA_W=14, SCAN_DIV=4. Hold rst_n=0 two cycles, then release -> an=4'hF, seg=7'h7F, busy=0. Then, 4 cycles after release -> an=4'hE, seg=7'h40.
- Decimal load 1234 -> busy=1 for exactly 15 cycles. Scanning then gives an=E/D/B/7 with seg=19/30/24/79 respectively.
- Decimal 7, blank_lz=1 -> an[0] slot seg=78, slots 1..3 seg=7F. Toggle blank_lz=0 -> slots 1..3 seg=40 from the next slot update.
- Decimal 12000 -> all four slots seg=3F. Decimal 9999 -> all slots 18 (no overflow).
- Hex 0x0ABC -> busy=1 for one cycle; slots 0..3 seg=46,03,08,40. With blank_lz=1, slot 3 seg=7F.
- Decimal 42, then in_valid with 99 at cycle 5 of busy -> the 99 is ignored and 42 is displayed. Assert rst_n=0 during a second conversion -> busy=0 next cycle and the display returns to reset state.
